// File: rtl/stream_ctrl_pkg.sv
// Shared types and default sizing for the streaming job controller.
package stream_ctrl_pkg;

    localparam int VECT_DEF         = 8;
    localparam int ADDRW_DEF        = 32;
    localparam int NINPUTS_DEF      = 2;
    localparam int WIW_DEF          = 16;
    localparam int MAX_INFLIGHT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/stream_job_ctrl_if.sv
// Kernel-facing stream and write-sink signals of the job controller.
interface stream_job_ctrl_if #(
    parameter int ADDRW   = 32,
    parameter int NINPUTS = 2
);
    // Valid/ready: a transfer happens in any cycle where valid and ready are both high;
    // once valid rises, it and its payload hold until that transfer. The input side
    // transfers only when every k_s_tready bit is high.
    logic [NINPUTS-1:0] k_s_tvalid;
    logic [NINPUTS-1:0] k_s_tready;
    logic [ADDRW-1:0]   rd_addr;
    logic               k_m_tvalid;
    logic               k_m_tready;
    logic               wr_ready;
    logic               wr_en;
    logic [ADDRW-1:0]   wr_addr;

    modport master (
        output k_s_tvalid, rd_addr, k_m_tready, wr_en, wr_addr,
        input  k_s_tready, k_m_tvalid, wr_ready
    );

    modport slave (
        input  k_s_tvalid, rd_addr, k_m_tready, wr_en, wr_addr,
        output k_s_tready, k_m_tvalid, wr_ready
    );

endinterface

// File: rtl/beat_addr_ctr.sv
// VECT-step element address counter that wraps after the last beat of a work instance.
module beat_addr_ctr
    import stream_ctrl_pkg::*;
#(
    parameter int VECT  = VECT_DEF,
    parameter int ADDRW = ADDRW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [ADDRW-1:0] size,
    output logic [ADDRW-1:0] addr,
    output logic             wrap
);

    localparam logic [ADDRW-1:0] STEP = ADDRW'(VECT);

    assign wrap = en && (addr == size - STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (clr) begin
            addr <= '0;
        end else if (en) begin
            addr <= wrap ? '0 : addr + STEP;
        end
    end

endmodule

// File: rtl/stream_job_ctrl.sv
// Job sequencer: issues input beats to the kernel, collects output beats, counts work instances.
module stream_job_ctrl
    import stream_ctrl_pkg::*;
#(
    parameter int VECT         = VECT_DEF,
    parameter int ADDRW        = ADDRW_DEF,
    parameter int NINPUTS      = NINPUTS_DEF,
    parameter int WIW          = WIW_DEF,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             start,
    input  logic [ADDRW-1:0] cfg_size,
    input  logic [WIW-1:0]   cfg_nwi,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [WIW-1:0]   wi_count,
    output ctrl_state_t      dbg_state,
    stream_job_ctrl_if.master io
);

    localparam int              IFW    = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IFW-1:0]  IF_MAX = IFW'(MAX_INFLIGHT);

    ctrl_state_t      state, state_nxt;
    logic [ADDRW-1:0] size_q;
    logic [WIW-1:0]   nwi_q;
    logic [WIW-1:0]   issued_q;
    logic [IFW-1:0]   inflight_q;
    logic             hold_q;
    logic             err_q;

    logic             cfg_bad, start_ok, counting;
    logic             s_valid, accept, wr_fire;
    logic             rd_wrap, wr_wrap, issue_last, out_last;
    logic [ADDRW-1:0] rd_addr_w, wr_addr_w;

    assign cfg_bad  = (cfg_size == '0) || ((cfg_size % ADDRW'(VECT)) != '0) || (cfg_nwi == '0);
    assign start_ok = (state == IDLE) && start && !cfg_bad;
    assign counting = (state == RUN) || (state == DRAIN);

    // A beat already offered stays offered even if the inflight limit is hit meanwhile.
    assign s_valid  = (state == RUN) && (hold_q || (inflight_q < IF_MAX));
    assign accept   = s_valid && (&io.k_s_tready);
    assign wr_fire  = io.wr_en && counting;

    assign io.k_s_tvalid = {NINPUTS{s_valid}};
    assign io.k_m_tready = busy && io.wr_ready;
    assign io.wr_en      = io.k_m_tvalid && io.k_m_tready;
    assign io.rd_addr    = rd_addr_w;
    assign io.wr_addr    = wr_addr_w;

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign cfg_err   = err_q;
    assign dbg_state = state;

    assign issue_last = rd_wrap && ((issued_q + WIW'(1)) == nwi_q);
    assign out_last   = wr_wrap && ((wi_count + WIW'(1)) == nwi_q);

    beat_addr_ctr #(.VECT(VECT), .ADDRW(ADDRW)) u_rd_ctr (
        .clk  (aclk),
        .rst  (areset),
        .clr  (start_ok),
        .en   (accept),
        .size (size_q),
        .addr (rd_addr_w),
        .wrap (rd_wrap)
    );

    beat_addr_ctr #(.VECT(VECT), .ADDRW(ADDRW)) u_wr_ctr (
        .clk  (aclk),
        .rst  (areset),
        .clr  (start_ok),
        .en   (wr_fire),
        .size (size_q),
        .addr (wr_addr_w),
        .wrap (wr_wrap)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = RUN;
            RUN: begin
                if (out_last)        state_nxt = DONE;
                else if (issue_last) state_nxt = DRAIN;
            end
            DRAIN:   if (out_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            size_q     <= '0;
            nwi_q      <= '0;
            issued_q   <= '0;
            wi_count   <= '0;
            inflight_q <= '0;
            hold_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state  <= state_nxt;
            err_q  <= (state == IDLE) && start && cfg_bad;
            hold_q <= s_valid && !accept;
            if (start_ok) begin
                size_q     <= cfg_size;
                nwi_q      <= cfg_nwi;
                issued_q   <= '0;
                wi_count   <= '0;
                inflight_q <= '0;
            end else begin
                if (rd_wrap) issued_q <= issued_q + WIW'(1);
                if (wr_wrap) wi_count <= wi_count + WIW'(1);
                case ({accept, wr_fire})
                    2'b10:   inflight_q <= inflight_q + IFW'(1);
                    2'b01:   inflight_q <= inflight_q - IFW'(1);
                    default: inflight_q <= inflight_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stream_job_ctrl.sv
// Directed bench for stream_job_ctrl with a transaction-level model and a latency kernel.
module tb_stream_job_ctrl;
    import stream_ctrl_pkg::*;

    localparam int VECT         = 8;
    localparam int ADDRW        = 32;
    localparam int NINPUTS      = 2;
    localparam int WIW          = 16;
    localparam int MAX_INFLIGHT = 4;

    logic             aclk;
    logic             areset;
    logic             start;
    logic [ADDRW-1:0] cfg_size;
    logic [WIW-1:0]   cfg_nwi;
    logic             busy, done, cfg_err;
    logic [WIW-1:0]   wi_count;
    ctrl_state_t      dbg_state;

    stream_job_ctrl_if #(.ADDRW(ADDRW), .NINPUTS(NINPUTS)) bus ();

    stream_job_ctrl #(
        .VECT(VECT), .ADDRW(ADDRW), .NINPUTS(NINPUTS), .WIW(WIW), .MAX_INFLIGHT(MAX_INFLIGHT)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .start     (start),
        .cfg_size  (cfg_size),
        .cfg_nwi   (cfg_nwi),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err),
        .wi_count  (wi_count),
        .dbg_state (dbg_state),
        .io        (bus.master)
    );

    // clock / reset
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // scoreboard counters
    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // behavioural model state
    logic [ADDRW-1:0] exp_rd_q[$];
    logic [ADDRW-1:0] exp_wr_q[$];
    logic [ADDRW-1:0] acc_log[$];
    bit  m_busy = 0, m_done_now = 0, m_err_now = 0, m_hold = 0;
    int  m_issue_left = 0, m_out_left = 0, m_inflight = 0, m_wr_done = 0, m_bpw = 1, m_max_if = 0;
    int  acc_cnt = 0, wr_cnt = 0, done_cnt = 0, err_cnt = 0;
    bit  c_busy, c_run, c_acc, c_wr;
    logic [NINPUTS-1:0] c_exp_sv;

    // stimulus knobs
    int  k_lat = 5;
    bit  k_spur = 0;
    bit  rdy_mode = 0;
    int  kq[$];
    logic [NINPUTS-1:0] rdy_pat [8] = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b11, 2'b10, 2'b11, 2'b01};

    // kernel model: each accepted beat reappears k_lat cycles later, in order
    initial begin
        bus.k_m_tvalid = 1'b0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                kq.delete();
            end else begin
                if (bus.k_s_tvalid == '1 && bus.k_s_tready == '1) kq.push_back(cyc + k_lat);
                if (bus.wr_en && kq.size() > 0) void'(kq.pop_front());
            end
            @(posedge aclk);
            #1;
            bus.k_m_tvalid = k_spur || (kq.size() > 0 && kq[0] <= cyc);
        end
    end

    // input-ready driver
    initial begin
        int pi = 0;
        bus.k_s_tready = '1;
        forever begin
            @(posedge aclk);
            #1;
            if (rdy_mode) begin
                bus.k_s_tready = rdy_pat[pi];
                pi = (pi + 1) % 8;
            end else begin
                bus.k_s_tready = '1;
            end
        end
    end

    // compare process
    initial begin
        forever begin
            @(negedge aclk);
            if (areset) begin
                check("rst_busy", busy, 1'b0);
                check("rst_done", done, 1'b0);
                check("rst_cfg_err", cfg_err, 1'b0);
                check("rst_wi_count", wi_count, '0);
                check("rst_k_s_tvalid", bus.k_s_tvalid, '0);
                check("rst_rd_addr", bus.rd_addr, '0);
                check("rst_wr_addr", bus.wr_addr, '0);
                check("rst_wr_en", bus.wr_en, 1'b0);
                m_busy = 0; m_done_now = 0; m_err_now = 0; m_hold = 0;
                m_issue_left = 0; m_out_left = 0; m_inflight = 0; m_wr_done = 0; m_bpw = 1;
                exp_rd_q.delete();
                exp_wr_q.delete();
            end else begin
                c_busy   = m_busy;
                c_run    = m_busy && (m_issue_left > 0);
                c_exp_sv = (c_run && (m_hold || m_inflight < MAX_INFLIGHT)) ? '1 : '0;
                check("k_s_tvalid", bus.k_s_tvalid, c_exp_sv);
                check("busy", busy, m_busy);
                check("done", done, m_done_now);
                check("cfg_err", cfg_err, m_err_now);
                check("wi_count", wi_count, 64'(m_wr_done / m_bpw));
                check("k_m_tready", bus.k_m_tready, m_busy && bus.wr_ready);
                check("wr_en", bus.wr_en, m_busy && bus.wr_ready && bus.k_m_tvalid);
                if (bus.k_s_tvalid != '0 && exp_rd_q.size() > 0) check("rd_addr", bus.rd_addr, exp_rd_q[0]);
                if (m_busy && exp_wr_q.size() > 0) check("wr_addr", bus.wr_addr, exp_wr_q[0]);

                c_acc = (bus.k_s_tvalid == '1) && (bus.k_s_tready == '1);
                c_wr  = bus.wr_en;
                if (c_acc) begin
                    acc_cnt++;
                    acc_log.push_back(bus.rd_addr);
                    if (exp_rd_q.size() > 0) void'(exp_rd_q.pop_front());
                    m_issue_left--;
                end
                m_hold = (c_exp_sv != '0) && !c_acc;
                if (c_wr) begin
                    wr_cnt++;
                    if (exp_wr_q.size() > 0) void'(exp_wr_q.pop_front());
                    m_out_left--;
                    m_wr_done++;
                end
                m_inflight = m_inflight + (c_acc ? 1 : 0) - (c_wr ? 1 : 0);
                if (m_inflight > m_max_if) m_max_if = m_inflight;
                if (done) done_cnt++;
                if (cfg_err) err_cnt++;

                if (m_done_now) m_busy = 0;
                m_done_now = c_busy && c_wr && (m_out_left == 0);
                m_err_now  = 0;
                if (start && !c_busy) begin
                    if (cfg_size == '0 || (cfg_size % VECT) != 0 || cfg_nwi == '0) begin
                        m_err_now = 1;
                    end else begin
                        m_bpw        = int'(cfg_size) / VECT;
                        m_issue_left = m_bpw * int'(cfg_nwi);
                        m_out_left   = m_issue_left;
                        m_wr_done    = 0;
                        m_inflight   = 0;
                        m_hold       = 0;
                        m_busy       = 1;
                        exp_rd_q.delete();
                        exp_wr_q.delete();
                        for (int w = 0; w < int'(cfg_nwi); w++) begin
                            for (int b = 0; b < m_bpw; b++) begin
                                exp_rd_q.push_back(ADDRW'(b * VECT));
                                exp_wr_q.push_back(ADDRW'(b * VECT));
                            end
                        end
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic pulse_start(input int size, input int nwi);
        @(posedge aclk);
        #1;
        start    = 1'b1;
        cfg_size = ADDRW'(size);
        cfg_nwi  = WIW'(nwi);
        @(posedge aclk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge aclk);
            n++;
        end
        check(name, done, 1'b1);
        tick(2);
    endtask

    int a0, w0, d0, e0;
    logic [ADDRW-1:0] seq2 [6] = '{0, 8, 0, 8, 0, 8};

    initial begin
        areset = 1'b1; start = 1'b0; cfg_size = '0; cfg_nwi = '0;
        bus.wr_ready = 1'b1;
        tick(3);
        check("reset_state", dbg_state, IDLE);
        areset = 1'b0;
        tick(2);

        // single work instance
        a0 = acc_cnt; w0 = wr_cnt; d0 = done_cnt;
        pulse_start(64, 1);
        wait_done("t1_done", 400);
        check("t1_wi_count", wi_count, 16'd1);
        check("t1_accepts", acc_cnt - a0, 8);
        check("t1_writes", wr_cnt - w0, 8);
        check("t1_done_pulses", done_cnt - d0, 1);
        check("t1_idle", dbg_state, IDLE);

        // multiple work instances
        a0 = acc_cnt; w0 = wr_cnt; d0 = done_cnt;
        acc_log.delete();
        pulse_start(16, 3);
        wait_done("t2_done", 400);
        check("t2_wi_count", wi_count, 16'd3);
        check("t2_writes", wr_cnt - w0, 6);
        check("t2_done_pulses", done_cnt - d0, 1);
        check("t2_accepts", acc_log.size(), 6);
        for (int i = 0; i < 6 && i < acc_log.size(); i++) check("t2_rd_seq", acc_log[i], seq2[i]);

        // inflight limit with the sink blocked
        bus.wr_ready = 1'b0;
        m_max_if = 0;
        a0 = acc_cnt;
        pulse_start(64, 1);
        tick(20);
        check("t3_accepts_blocked", acc_cnt - a0, 4);
        check("t3_valid_low", bus.k_s_tvalid, '0);
        bus.wr_ready = 1'b1;
        wait_done("t3_done", 400);
        check("t3_accepts_total", acc_cnt - a0, 8);
        check("t3_max_inflight", m_max_if, MAX_INFLIGHT);

        // input ready stalls, including split lanes
        rdy_mode = 1'b1;
        a0 = acc_cnt;
        pulse_start(64, 2);
        wait_done("t4_done", 600);
        rdy_mode = 1'b0;
        check("t4_accepts", acc_cnt - a0, 16);
        check("t4_wi_count", wi_count, 16'd2);

        // config errors and start while busy
        e0 = err_cnt;
        pulse_start(12, 1);
        tick(2);
        check("t5_err_size", err_cnt - e0, 1);
        check("t5_busy_size", busy, 1'b0);
        pulse_start(64, 0);
        tick(2);
        check("t5_err_nwi", err_cnt - e0, 2);
        pulse_start(0, 2);
        tick(2);
        check("t5_err_zero", err_cnt - e0, 3);
        check("t5_busy_zero", busy, 1'b0);
        w0 = wr_cnt;
        pulse_start(16, 1);
        tick(1);
        pulse_start(64, 4);
        wait_done("t5_done", 400);
        check("t5_ignored_start_wi", wi_count, 16'd1);
        check("t5_ignored_start_wr", wr_cnt - w0, 2);
        k_spur = 1'b1;
        tick(3);
        k_spur = 1'b0;
        tick(2);

        // asynchronous reset mid-job, then a clean job
        pulse_start(64, 1);
        tick(6);
        @(posedge aclk);
        #3;
        areset = 1'b1;
        #1;
        check("t6_busy", busy, 1'b0);
        check("t6_k_s_tvalid", bus.k_s_tvalid, '0);
        check("t6_rd_addr", bus.rd_addr, '0);
        check("t6_wr_addr", bus.wr_addr, '0);
        check("t6_wi_count", wi_count, '0);
        check("t6_k_m_tready", bus.k_m_tready, 1'b0);
        tick(2);
        areset = 1'b0;
        tick(2);
        a0 = acc_cnt; w0 = wr_cnt;
        pulse_start(64, 1);
        wait_done("t6_done", 400);
        check("t6_wi_after", wi_count, 16'd1);
        check("t6_accepts", acc_cnt - a0, 8);
        check("t6_writes", wr_cnt - w0, 8);

        tick(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
